// File: rtl/rot_shift_pipe.sv
// Pipelined rotate/shift unit for the SHA-256 datapath: runtime amount and mode,
// valid/ready stream with full backpressure, opaque tag carried alongside each beat.
module rot_shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int unsigned LVLS = $clog2(WIDTH);
  localparam int unsigned NSTG = STAGES;

  logic             adv;

  logic             valid_q [NSTG];
  logic [WIDTH-1:0] data_q  [NSTG];
  logic [LVLS-1:0]  amt_q   [NSTG];
  logic [1:0]       mode_q  [NSTG];
  logic [TAG_W-1:0] tag_q   [NSTG];

  logic             valid_d [NSTG];
  logic [WIDTH-1:0] data_d  [NSTG];
  logic [LVLS-1:0]  amt_d   [NSTG];
  logic [1:0]       mode_d  [NSTG];
  logic [TAG_W-1:0] tag_d   [NSTG];

  logic             src_valid [NSTG];
  logic [WIDTH-1:0] src_data  [NSTG];
  logic [LVLS-1:0]  src_amt   [NSTG];
  logic [1:0]       src_mode  [NSTG];
  logic [TAG_W-1:0] src_tag   [NSTG];

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

  // Left modes run through the same right-going network: the operand is
  // bit-reversed on entry and the result reversed again in the last stage.
  for (genvar g = 0; g < STAGES; g++) begin : g_src
    if (g == 0) begin : g_first
      assign src_valid[g] = in_valid;
      assign src_data[g]  = in_mode[1] ? bit_rev(in_data) : in_data;
      assign src_amt[g]   = in_amt;
      assign src_mode[g]  = in_mode;
      assign src_tag[g]   = in_tag;
    end else begin : g_next
      assign src_valid[g] = valid_q[g-1];
      assign src_data[g]  = data_q[g-1];
      assign src_amt[g]   = amt_q[g-1];
      assign src_mode[g]  = mode_q[g-1];
      assign src_tag[g]   = tag_q[g-1];
    end
  end

  // Level k (shift by 2^k) belongs to stage floor(k*STAGES/LVLS).
  always_comb begin
    logic [WIDTH-1:0] cur;
    int unsigned      sh;
    cur = '0;
    sh  = 0;
    for (int unsigned s = 0; s < NSTG; s++) begin
      cur = src_data[s];
      for (int unsigned k = 0; k < LVLS; k++) begin
        if (((k * NSTG) / LVLS) == s && src_amt[s][k]) begin
          sh = 32'd1 << k;
          if (src_mode[s][0]) begin
            cur = cur >> sh;
          end else begin
            cur = (cur >> sh) | (cur << (WIDTH - sh));
          end
        end
      end
      if (s == NSTG - 1 && src_mode[s][1]) begin
        cur = bit_rev(cur);
      end
      valid_d[s] = src_valid[s];
      data_d[s]  = cur;
      amt_d[s]   = src_amt[s];
      mode_d[s]  = src_mode[s];
      tag_d[s]   = src_tag[s];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NSTG; s++) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        amt_q[s]   <= '0;
        mode_q[s]  <= '0;
        tag_q[s]   <= '0;
      end
    end else if (adv) begin
      for (int unsigned s = 0; s < NSTG; s++) begin
        valid_q[s] <= valid_d[s];
        data_q[s]  <= data_d[s];
        amt_q[s]   <= amt_d[s];
        mode_q[s]  <= mode_d[s];
        tag_q[s]   <= tag_d[s];
      end
    end
  end

  assign adv       = !valid_q[NSTG-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[NSTG-1];
  assign out_data  = data_q[NSTG-1];
  assign out_tag   = tag_q[NSTG-1];

endmodule

// File: tb/tb_rot_shift_pipe.sv
// Directed bench for rot_shift_pipe (WIDTH=32, STAGES=2, TAG_W=4): hand-computed
// results, latency/ordering, backpressure, bubbles and mid-stream reset.
module tb_rot_shift_pipe;

  localparam int STG = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;

  rot_shift_pipe #(.WIDTH(32), .STAGES(STG), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Consumed result beats, stamped with the index of the consuming edge.
  logic [31:0] got_d[$];
  logic [3:0]  got_t[$];
  int unsigned got_c[$];
  int unsigned mon_cyc = 0;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_t.push_back(out_tag);
      got_c.push_back(mon_cyc);
    end
    mon_cyc++;
  end

  task automatic clear_log();
    got_d.delete();
    got_t.delete();
    got_c.delete();
  endtask

  task automatic put(input logic v, input logic [31:0] d, input logic [4:0] a,
                     input logic [1:0] m, input logic [3:0] t);
    in_valid = v;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    in_tag   = t;
  endtask

  task automatic wait_beats(input int n);
    int b;
    b = 0;
    while (got_d.size() < n && b < 50) begin
      @(negedge clk);
      b++;
    end
    repeat (4) @(negedge clk);
    chk("beat_count", 32'(got_d.size()), 32'(n));
  endtask

  localparam logic [1:0] ROTR = 2'd0, SHR = 2'd1, ROTL = 2'd2, SHL = 2'd3;

  logic [31:0] vd [5];
  logic [4:0]  va [5];
  logic [1:0]  vm [5];
  logic [31:0] ve [5];
  int unsigned acc;
  int          sent;
  int          sidx;
  logic        stall_on;
  logic [31:0] hold_d;
  logic [3:0]  hold_t;
  logic [7:0]  vpat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    put(1'b0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic ROTR, exact latency
    @(negedge clk);
    clear_log();
    put(1'b1, 32'h12345678, 5'd4, ROTR, 4'd3);
    @(negedge clk);
    put(1'b0, '0, '0, '0, '0);
    chk("basic_early_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", out_data, 32'h81234567);
    chk("basic_tag", 32'(out_tag), 32'd3);
    repeat (3) @(negedge clk);

    // Mode sweep, back to back
    clear_log();
    vd[0] = 32'h12345678; va[0] = 5'd4;  vm[0] = SHR;  ve[0] = 32'h01234567;
    vd[1] = 32'h12345678; va[1] = 5'd8;  vm[1] = ROTL; ve[1] = 32'h34567812;
    vd[2] = 32'h00000001; va[2] = 5'd31; vm[2] = SHL;  ve[2] = 32'h80000000;
    vd[3] = 32'h00000001; va[3] = 5'd31; vm[3] = ROTR; ve[3] = 32'h00000002;
    acc = mon_cyc;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, vd[i], va[i], vm[i], 4'(i + 8));
      @(negedge clk);
    end
    put(1'b0, '0, '0, '0, '0);
    wait_beats(4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      chk($sformatf("sweep_data%0d", i), got_d[i], ve[i]);
      chk($sformatf("sweep_tag%0d", i), 32'(got_t[i]), 32'(i + 8));
      chk($sformatf("sweep_cyc%0d", i), 32'(got_c[i]), 32'(acc + STG + i));
    end

    // Edge amounts
    clear_log();
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 32'hDEADBEEF, 5'd0, 2'(i), 4'(i));
      @(negedge clk);
    end
    put(1'b1, 32'h80000000, 5'd31, SHR, 4'd4);
    @(negedge clk);
    put(1'b0, '0, '0, '0, '0);
    wait_beats(5);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      chk($sformatf("a0_data%0d", i), got_d[i], 32'hDEADBEEF);
      chk($sformatf("a0_tag%0d", i), 32'(got_t[i]), 32'(i));
    end
    if (got_d.size() >= 5) chk("shr31_data", got_d[4], 32'h00000001);

    // Backpressure: 3-cycle stall once the first result shows
    clear_log();
    sent = 0;
    sidx = 0;
    stall_on = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!stall_on && out_valid) stall_on = 1'b1;
      if (stall_on && sidx < 4) begin
        if (sidx == 0) begin
          hold_d = out_data;
          hold_t = out_tag;
        end else begin
          chk("bp_hold_valid", 32'(out_valid), 32'd1);
          chk("bp_hold_data", out_data, hold_d);
          chk("bp_hold_tag", 32'(out_tag), 32'(hold_t));
        end
        out_ready = (sidx >= 3);
        sidx++;
      end else begin
        out_ready = 1'b1;
      end
      if (sent < 5) put(1'b1, 32'h1, 5'(sent), SHL, 4'(sent));
      else          put(1'b0, '0, '0, '0, '0);
      #1;
      if (!out_ready) chk("bp_in_ready", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    put(1'b0, '0, '0, '0, '0);
    chk("bp_sent", 32'(sent), 32'd5);
    chk("bp_stalled", 32'(sidx), 32'd4);
    wait_beats(5);
    for (int i = 0; i < 5 && i < got_d.size(); i++) begin
      chk($sformatf("bp_data%0d", i), got_d[i], 32'h1 << i);
      chk($sformatf("bp_tag%0d", i), 32'(got_t[i]), 32'(i));
    end

    // Bubbles: in_valid 1,0,1,0,1
    clear_log();
    vd[0] = 32'h00000003; va[0] = 5'd1;  vm[0] = ROTR; ve[0] = 32'h80000001;
    vd[1] = 32'h80000000; va[1] = 5'd1;  vm[1] = ROTL; ve[1] = 32'h00000001;
    vd[2] = 32'hABCD0000; va[2] = 5'd16; vm[2] = SHR;  ve[2] = 32'h0000ABCD;
    vpat = '0;
    for (int c = 0; c < 8; c++) begin
      vpat[c] = out_valid;
      if (c < 5 && (c % 2) == 0) put(1'b1, vd[c/2], va[c/2], vm[c/2], 4'(c));
      else                       put(1'b0, '0, '0, '0, '0);
      @(negedge clk);
    end
    chk("bubble_pattern", 32'(vpat), 32'b0101_0100);
    wait_beats(3);
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      chk($sformatf("bubble_data%0d", i), got_d[i], ve[i]);
      chk($sformatf("bubble_tag%0d", i), 32'(got_t[i]), 32'(2 * i));
    end

    // Reset with two beats in flight, plus one offered on the reset edge
    clear_log();
    put(1'b1, 32'h11111111, 5'd1, ROTR, 4'd5);
    @(negedge clk);
    put(1'b1, 32'h22222222, 5'd2, SHL, 4'd6);
    @(negedge clk);
    rst_n = 1'b0;
    put(1'b1, 32'h33333333, 5'd3, SHR, 4'd7);
    @(negedge clk);
    rst_n = 1'b1;
    put(1'b0, '0, '0, '0, '0);
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_data", out_data, 32'd0);
    chk("mrst_out_tag", 32'(out_tag), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("mrst_still_empty", 32'(out_valid), 32'd0);
    put(1'b1, 32'h0F0F0F0F, 5'd4, SHL, 4'd9);
    @(negedge clk);
    put(1'b0, '0, '0, '0, '0);
    chk("mrst_new_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("mrst_new_valid", 32'(out_valid), 32'd1);
    chk("mrst_new_data", out_data, 32'hF0F0F0F0);
    chk("mrst_new_tag", 32'(out_tag), 32'd9);
    wait_beats(1);
    if (got_d.size() >= 1) chk("mrst_only_tag", 32'(got_t[0]), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
